serial_tx_shifter: RTL
======================

# serial_tx_shifter

Parallel-to-serial transmitter that feeds the serial bit-sequence checker's `Din` input. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per clock on `Dout`, with an optional idle gap between words. Frame markers (`bit_valid`, `last_bit`) let downstream stages and benches align words to the bitstream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `GAP`, default 0: number of idle cycles inserted between consecutive words; legal range is 0..15.
- `IDLE_LEVEL`, default 0: value driven on `Dout` whenever no bit is being sent.

- `clk`, input, 1: single clock; all state changes on its posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `data_in`, input, WIDTH: word to transmit.
- `valid_in`, input, 1: `data_in` is valid.
- `ready_out`, output, 1: the block will take `data_in` at this edge.
- `Dout`, output, 1: registered serial bit; connects to the checker's `Din`.
- `bit_valid`, output, 1: `Dout` carries a data bit this cycle.
- `last_bit`, output, 1: the current `Dout` bit is the final bit of its word.
- `busy`, output, 1: the shifter or the holding register is occupied.

## Operation
- Storage:
  - `hold` register plus `hold_full` flag.
  - `shreg` shift register, WIDTH bits.
  - Bit counter, ceil(log2(WIDTH)) bits.
  - Gap counter, 4 bits.
- States:
  - IDLE: nothing is shifting.
  - SHIFT: a word is being sent.
  - GAP: idle cycles between words; GAP state is skipped entirely when GAP=0.
- Handshake:
  - A word is accepted at a posedge where `valid_in && ready_out`; `data_in` is written to `hold` and `hold_full` is set.
  - `ready_out = !hold_full || load`. It depends only on registered state, never on `valid_in`.
- The `load` condition is `hold_full` and any one of:
  - state is IDLE;
  - state is SHIFT at the last bit with GAP=0;
  - state is GAP on its last gap cycle.
- On `load`:
  - `hold` is copied into `shreg` and the bit counter clears.
  - State goes to SHIFT.
  - `hold_full` clears, unless a new word is accepted at the same edge, in which case it stays set with the new data.
- SHIFT:
  - Each cycle `Dout` presents the next bit: `shreg` MSB if MSB_FIRST, else LSB. `shreg` shifts and the counter increments.
  - At counter = WIDTH-1, `last_bit` is 1.
  - After the last bit, the next state is, in priority order: SHIFT (back-to-back) if `load`, else GAP if GAP>0, else IDLE.
- GAP:
  - Lasts exactly GAP cycles with `Dout=IDLE_LEVEL` and `bit_valid=0`.
  - Then goes to SHIFT if `hold_full`, else IDLE.
  - Words that arrive during GAP wait in `hold`.
- Outputs:
  - `bit_valid = (state == SHIFT)`.
  - `busy = (state != IDLE) || hold_full`.
  - `Dout = IDLE_LEVEL` whenever `bit_valid=0`.
- Reset values (asynchronous, on `rst_n=0`):
  - state=IDLE, `hold_full=0`, both counters=0.
  - `Dout=IDLE_LEVEL`, `bit_valid=0`, `last_bit=0`, `busy=0`, `ready_out=1`.
  - Reset asserted mid-word abandons the word and the held word with no partial completion.
- Parameters outside their legal range are a configuration error and need no runtime check.

## Timing
- Latency:
  - A word accepted at edge N while IDLE with `hold` empty loads at edge N+1.
  - Its first bit is on `Dout` from edge N+1 until edge N+2.
  - Its last bit is on `Dout` from edge N+WIDTH until edge N+WIDTH+1.
- Throughput:
  - GAP=0: sustained at one word per WIDTH cycles with `bit_valid` continuously high.
  - GAP>0: one word per WIDTH+GAP cycles.
- Back-to-back words:
  - `ready_out` stays low while `hold` is full and no `load` is occurring.
  - With GAP=0, `ready_out` rises during the last-bit cycle, so a word presented then is accepted without a bubble in the handshake.
- `valid_in` asserted while `ready_out=0`: the word is not captured; the upstream source must hold `data_in` stable until the handshake completes.

## Test plan
- Single word, IDLE, WIDTH=8, MSB_FIRST=1, `data_in=8'hE5` accepted at edge 0:
  - `Dout` = 1,1,1,0,0,1,0,1 during cycles 1..8, with `bit_valid` high during cycles 1..8.
  - `last_bit` high only in cycle 8.
  - Cycle 9: IDLE, `Dout=0`, `busy=0`.
- MSB_FIRST=0, `8'hE5`: bits sent are 1,0,1,0,0,1,1,1.
- Back-to-back, GAP=0, `valid_in` held high with words `8'hFF` then `8'h0F`:
  - 16 contiguous bits with `bit_valid` never dropping.
  - `ready_out` low between the two accepts except in the last-bit cycle.
  - The checker downstream sees the run of 1s.
- GAP=2, two queued words: exactly 2 cycles with `bit_valid=0` and `Dout=IDLE_LEVEL` between the first word's last bit and the second word's first bit.
- Backpressure, `valid_in` high for 3 words at the start:
  - Accepts at edge 0 and edge 1; the third word is accepted only at the first word's last-bit edge.
  - No word is lost or duplicated.
- Reset: `rst_n` pulsed low at bit 4 of a word with `hold` full:
  - `Dout`, `bit_valid`, `busy` and `hold_full` clear immediately, without waiting for a clock edge.
  - After release, `ready_out=1` and a new word transmits correctly.

Source files
------------

// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: a one-word holding register feeds a shift register
// that emits one bit per clock, with an optional idle gap between words.
module serial_tx_shifter #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             Dout,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             dout_q;

  logic at_last;
  logic gap_done;
  logic load;
  logic accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  assign at_last   = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
  assign gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign load      = hold_full && ((state == ST_IDLE) || (at_last && (GAP == 0)) || gap_done);
  assign ready_out = !hold_full || load;
  assign accept    = valid_in && ready_out;

  assign bit_valid = (state == ST_SHIFT);
  assign last_bit  = at_last;
  assign busy      = (state != ST_IDLE) || hold_full;
  assign Dout      = dout_q;

  // Control: state, occupancy, counters and the registered serial bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      dout_q    <= IDLE_LEVEL;
    end else begin
      if (load)        hold_full <= accept;
      else if (accept) hold_full <= 1'b1;

      if (load) begin
        state   <= ST_SHIFT;
        bit_cnt <= '0;
        gap_cnt <= '0;
        dout_q  <= first_bit(hold);
      end else begin
        case (state)
          ST_SHIFT: begin
            if (at_last) begin
              dout_q  <= IDLE_LEVEL;
              gap_cnt <= '0;
              state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              dout_q  <= first_bit(shreg);
            end
          end
          ST_GAP: begin
            if (gap_done) state <= ST_IDLE;
            else          gap_cnt <= gap_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Data: shreg always holds the bits still to be sent after the one on Dout.
  always_ff @(posedge clk) begin
    if (accept) hold <= data_in;
    if (load)
      shreg <= shift_out(hold);
    else if ((state == ST_SHIFT) && !at_last)
      shreg <= shift_out(shreg);
  end

endmodule
